// File: rtl/arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq.sv
// BIST address sequencer: walks the word address up/down over NUM_PASS march passes with a flopped one-hot wordline select.
// Optional one-hot checker enabled by defining ARF070B144E1R1W0CBBEHEAA4ACW_BIST_ONEHOT_CHK_EN.
module arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq #(
   parameter int DEPTH      = 70,
   parameter int NUM_PASS   = 1,
   parameter int ALT_DIR    = 1,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int PASS_WIDTH = $clog2(NUM_PASS + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  dir,
   input  logic                  adv,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DEPTH-1:0]      wl_sel,
   output logic                  sel_vld,
   output logic                  cur_dir,
   output logic [PASS_WIDTH-1:0] pass_idx,
   output logic                  busy,
   output logic                  done,
   output logic                  onehot_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [DEPTH-1:0]      WL_FIRST  = DEPTH'(1);
   localparam logic [DEPTH-1:0]      WL_LAST   = WL_FIRST << (DEPTH - 1);
   localparam logic [PASS_WIDTH-1:0] PASS_LAST = PASS_WIDTH'(NUM_PASS - 1);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DEPTH-1:0]        wl_sel_q;
   logic                    sel_vld_q;
   logic                    cur_dir_q;
   logic [PASS_WIDTH-1:0]   pass_idx_q;
   logic                    busy_q;
   logic                    done_q;

   logic                    pass_end_d;
   logic                    last_pass_d;
   logic                    nxt_dir_d;
   logic [ADDR_WIDTH-1:0]   reload_addr_d;
   logic [DEPTH-1:0]        reload_wl_d;

   always_comb begin
      pass_end_d    = cur_dir_q ? (addr_q == '0) : (addr_q == ADDR_LAST);
      last_pass_d   = (pass_idx_q == PASS_LAST);
      nxt_dir_d     = (ALT_DIR != 0) ? ~cur_dir_q : cur_dir_q;
      reload_addr_d = nxt_dir_d ? ADDR_LAST : '0;
      reload_wl_d   = nxt_dir_d ? WL_LAST : WL_FIRST;
   end

   // wl_sel is shifted alongside addr rather than decoded, so the select stays a pure flop output.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      if (rst || abort) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wl_sel_q   <= '0;
         sel_vld_q  <= 1'b0;
         cur_dir_q  <= 1'b0;
         pass_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_RUN;
                  addr_q     <= dir ? ADDR_LAST : '0;
                  wl_sel_q   <= dir ? WL_LAST : WL_FIRST;
                  sel_vld_q  <= 1'b1;
                  cur_dir_q  <= dir;
                  pass_idx_q <= '0;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               if (adv) begin
                  if (!pass_end_d) begin
                     addr_q   <= cur_dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
                     wl_sel_q <= cur_dir_q ? wl_sel_q >> 1 : wl_sel_q << 1;
                  end else if (!last_pass_d) begin
                     pass_idx_q <= pass_idx_q + 1'b1;
                     cur_dir_q  <= nxt_dir_d;
                     addr_q     <= reload_addr_d;
                     wl_sel_q   <= reload_wl_d;
                  end else begin
                     state_q   <= S_DONE;
                     wl_sel_q  <= '0;
                     sel_vld_q <= 1'b0;
                     done_q    <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef ARF070B144E1R1W0CBBEHEAA4ACW_BIST_ONEHOT_CHK_EN
   logic onehot_err_q;
   logic wl_onehot_d;
   logic wl_match_d;

   always_comb begin
      wl_onehot_d = (wl_sel_q != '0) && ((wl_sel_q & (wl_sel_q - 1'b1)) == '0);
      wl_match_d  = (wl_sel_q == (WL_FIRST << addr_q));
   end

   // Sticky until rst; abort deliberately leaves the flag alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         onehot_err_q <= 1'b0;
      end else if (sel_vld_q && (!wl_onehot_d || !wl_match_d)) begin
         onehot_err_q <= 1'b1;
      end
   end

   assign onehot_err = onehot_err_q;
`else
   assign onehot_err = 1'b0;
`endif

   assign addr     = addr_q;
   assign wl_sel   = wl_sel_q;
   assign sel_vld  = sel_vld_q;
   assign cur_dir  = cur_dir_q;
   assign pass_idx = pass_idx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq.sv
// Scoreboard bench for the BIST address sequencer: three instances (2-pass alternating, 1-pass, 2-pass fixed-direction).
module tb_arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq;

   localparam int DEPTH = 70;

`ifdef ARF070B144E1R1W0CBBEHEAA4ACW_BIST_ONEHOT_CHK_EN
   localparam bit EXP_ERR = 1'b1;
`else
   localparam bit EXP_ERR = 1'b0;
`endif

   typedef struct {
      bit         chk_addr;
      bit         chk_misc;
      bit         chk_wl;
      logic [6:0] addr;
      logic       sel_vld;
      logic       cur_dir;
      logic [1:0] pass_idx;
      logic       busy;
      logic       done;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] start_v = '0;
   logic dir = 1'b0, adv = 1'b0, abort = 1'b0;

   logic [6:0] addr_a, addr_b, addr_c;
   logic [DEPTH-1:0] wl_a, wl_b, wl_c;
   logic sel_a, sel_b, sel_c, cd_a, cd_b, cd_c;
   logic [1:0] pass_a, pass_c;
   logic [0:0] pass_b;
   logic busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;

   exp_t q0[$], q1[$], q2[$];
   int total = 0, bad = 0;
   bit err_exp = 1'b0;
   string tname = "reset";

   always #5 clk = ~clk;

   arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq #(.DEPTH(DEPTH), .NUM_PASS(2), .ALT_DIR(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .dir(dir), .adv(adv), .abort(abort),
      .addr(addr_a), .wl_sel(wl_a), .sel_vld(sel_a), .cur_dir(cd_a), .pass_idx(pass_a),
      .busy(busy_a), .done(done_a), .onehot_err(err_a));

   arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq #(.DEPTH(DEPTH), .NUM_PASS(1), .ALT_DIR(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .dir(dir), .adv(adv), .abort(abort),
      .addr(addr_b), .wl_sel(wl_b), .sel_vld(sel_b), .cur_dir(cd_b), .pass_idx(pass_b),
      .busy(busy_b), .done(done_b), .onehot_err(err_b));

   arf070b144e1r1w0cbbeheaa4acw_bist_addr_seq #(.DEPTH(DEPTH), .NUM_PASS(2), .ALT_DIR(0)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .dir(dir), .adv(adv), .abort(abort),
      .addr(addr_c), .wl_sel(wl_c), .sel_vld(sel_c), .cur_dir(cd_c), .pass_idx(pass_c),
      .busy(busy_c), .done(done_c), .onehot_err(err_c));

   function automatic exp_t e_run(int a, bit d, int p);
      exp_t e;
      e.chk_addr = 1'b1; e.chk_misc = 1'b1; e.chk_wl = 1'b1;
      e.addr = 7'(a); e.sel_vld = 1'b1; e.cur_dir = d; e.pass_idx = 2'(p);
      e.busy = 1'b1; e.done = 1'b0; e.err = err_exp;
      return e;
   endfunction

   function automatic exp_t e_rst();
      exp_t e;
      e = e_run(0, 1'b0, 0);
      e.sel_vld = 1'b0; e.busy = 1'b0;
      return e;
   endfunction

   function automatic exp_t e_done(int a);
      exp_t e;
      e = e_run(a, 1'b0, 0);
      e.chk_misc = 1'b0; e.sel_vld = 1'b0; e.done = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_idle();
      exp_t e;
      e = e_rst();
      e.chk_addr = 1'b0; e.chk_misc = 1'b0;
      return e;
   endfunction

   task automatic cmp(input string nm, input exp_t e, input logic [6:0] a, input logic [DEPTH-1:0] w,
                      input logic sv, input logic cd, input logic [1:0] pi, input logic b,
                      input logic d, input logic er);
      logic [DEPTH-1:0] ew;
      logic [DEPTH-1:0] one;
      bit ok;
      one = DEPTH'(1);
      ew  = e.sel_vld ? (one << e.addr) : '0;
      ok  = (sv === e.sel_vld) && (b === e.busy) && (d === e.done) && (er === e.err);
      if (e.chk_wl)   ok = ok && (w === ew);
      if (e.chk_addr) ok = ok && (a === e.addr);
      if (e.chk_misc) ok = ok && (cd === e.cur_dir) && (pi === e.pass_idx);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s/%s t=%0t got addr=%0d vld=%b dir=%b pass=%0d busy=%b done=%b err=%b wl=%h | want addr=%0d vld=%b dir=%b pass=%0d busy=%b done=%b err=%b wl=%h",
                  tname, nm, $time, a, sv, cd, pi, b, d, er, w,
                  e.addr, e.sel_vld, e.cur_dir, e.pass_idx, e.busy, e.done, e.err, ew);
      end
   endtask

   // Monitor: one expectation per pushed cycle, checked 1 time unit after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() != 0) cmp("A", q0.pop_front(), addr_a, wl_a, sel_a, cd_a, pass_a, busy_a, done_a, err_a);
         if (q1.size() != 0) cmp("B", q1.pop_front(), addr_b, wl_b, sel_b, cd_b, {1'b0, pass_b}, busy_b, done_b, err_b);
         if (q2.size() != 0) cmp("C", q2.pop_front(), addr_c, wl_c, sel_c, cd_c, pass_c, busy_c, done_c, err_c);
      end
   end

   task automatic push(input int d, input exp_t e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic drv(input int d, input bit st, input bit dr, input bit ad, input bit ab, input exp_t e);
      @(negedge clk);
      start_v    = '0;
      start_v[d] = st;
      dir        = dr;
      adv        = ad;
      abort      = ab;
      push(d, e);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [DEPTH-1:0] bad_wl;
      int a;
      bit ad, st;

      for (int d = 0; d < 3; d++) push(d, e_rst());
      @(negedge clk);
      for (int d = 0; d < 3; d++) push(d, e_rst());
      @(negedge clk);
      rst = 1'b0;

      // Single pass up: 0..69, done one cycle after 69; start in last RUN and DONE cycles ignored.
      tname = "b_up1";
      drv(1, 1, 0, 1, 0, e_run(0, 0, 0));
      for (int k = 1; k < DEPTH; k++) drv(1, 0, 0, 1, 0, e_run(k, 0, 0));
      drv(1, 1, 0, 1, 0, e_done(DEPTH - 1));
      drv(1, 1, 0, 1, 0, e_idle());
      drv(1, 0, 0, 0, 0, e_idle());

      // Two alternating passes: 0..69 then 69..0 with no bubble.
      tname = "a_alt2";
      drv(0, 1, 0, 1, 0, e_run(0, 0, 0));
      for (int k = 1; k < DEPTH; k++) drv(0, 0, 0, 1, 0, e_run(k, 0, 0));
      for (int k = 0; k < DEPTH; k++) drv(0, 0, 0, 1, 0, e_run(DEPTH - 1 - k, 1, 1));
      drv(0, 0, 0, 1, 0, e_done(0));
      drv(0, 0, 0, 1, 0, e_idle());

      // Two fixed-direction passes starting down: 69..0 twice, cur_dir stays 1.
      tname = "c_fix2";
      drv(2, 1, 1, 1, 0, e_run(DEPTH - 1, 1, 0));
      for (int k = 1; k < DEPTH; k++) drv(2, 0, 0, 1, 0, e_run(DEPTH - 1 - k, 1, 0));
      for (int k = 0; k < DEPTH; k++) drv(2, 0, 0, 1, 0, e_run(DEPTH - 1 - k, 1, 1));
      drv(2, 0, 0, 1, 0, e_done(0));
      drv(2, 0, 0, 0, 0, e_idle());

      // Gapped advance with stray start (dir=1) mid-run, then abort with adv.
      tname = "b_gap";
      drv(1, 1, 0, 1, 0, e_run(0, 0, 0));
      a = 0;
      for (int i = 0; i < 12; i++) begin
         ad = (i % 3 == 0);
         st = (i == 4) || (i == 7);
         if (ad) a++;
         drv(1, st, 1, ad, 0, e_run(a, 0, 0));
      end
      drv(1, 0, 0, 1, 1, e_rst());
      drv(1, 0, 0, 1, 0, e_rst());

      // Abort at addr 35, then start+abort together.
      tname = "a_abort";
      drv(0, 1, 0, 1, 0, e_run(0, 0, 0));
      for (int k = 1; k <= 35; k++) drv(0, 0, 0, 1, 0, e_run(k, 0, 0));
      drv(0, 0, 0, 1, 1, e_rst());
      drv(0, 0, 0, 1, 0, e_rst());
      drv(0, 1, 1, 0, 1, e_rst());
      drv(0, 0, 0, 0, 0, e_rst());

      // Corrupt wl_sel mid-run: checker flag sets (if built), survives abort, cleared by rst.
      tname = "a_onehot";
      drv(0, 1, 1, 1, 0, e_run(DEPTH - 1, 1, 0));
      drv(0, 0, 0, 1, 0, e_run(DEPTH - 2, 1, 0));
      drv(0, 0, 0, 1, 0, e_run(DEPTH - 3, 1, 0));
      @(negedge clk);
      start_v = '0;
      adv     = 1'b0;
      abort   = 1'b0;
      bad_wl  = '0;
      bad_wl[3]  = 1'b1;
      bad_wl[10] = 1'b1;
      force dut_a.wl_sel_q = bad_wl;
      err_exp = EXP_ERR;
      begin
         exp_t e;
         e = e_run(DEPTH - 3, 1, 0);
         e.chk_wl = 1'b0;
         push(0, e);
      end
      @(posedge clk);
      #2;
      release dut_a.wl_sel_q;
      drv(0, 0, 0, 0, 1, e_rst());
      drv(0, 0, 0, 0, 0, e_rst());
      drv(0, 1, 0, 0, 1, e_rst());
      @(negedge clk);
      abort   = 1'b0;
      start_v = '0;
      rst     = 1'b1;
      err_exp = 1'b0;
      push(0, e_rst());
      @(negedge clk);
      rst = 1'b0;
      push(0, e_rst());

      repeat (3) @(negedge clk);
      tname = "drain";
      total++;
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         bad++;
         $display("FAIL drain queues left=%0d required=0", q0.size() + q1.size() + q2.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
